// File: rtl/switch_pkg.sv
// switch_pkg: shared types and helpers for the N_IN x N_OUT registered switch.
//   latency_t       - downstream latency estimate
//   LAT_MAX         - saturation value of latency_t
//   sat_inc()       - saturating +1 on a latency estimate
//   argmin_latency()- lowest-index minimum-latency output among a mask
package switch_pkg;

    localparam int unsigned LAT_W   = 5;
    localparam int unsigned MAX_OUT = 16;

    typedef logic [LAT_W-1:0] latency_t;

    localparam latency_t LAT_MAX = '1;

    function automatic latency_t sat_inc(input latency_t lat);
        return (lat == LAT_MAX) ? LAT_MAX : latency_t'(lat + latency_t'(1));
    endfunction

    // Returns MAX_OUT when the mask is empty.
    function automatic int unsigned argmin_latency(
        input logic     [MAX_OUT-1:0] mask,
        input latency_t [MAX_OUT-1:0] lats
    );
        int unsigned best;
        latency_t    best_lat;
        best     = MAX_OUT;
        best_lat = LAT_MAX;
        for (int unsigned i = 0; i < MAX_OUT; i++) begin
            // Strict compare keeps the lowest index on ties.
            if (mask[i] && ((best == MAX_OUT) || (lats[i] < best_lat))) begin
                best     = i;
                best_lat = lats[i];
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/switch_out_slot.sv
// switch_out_slot: single-entry registered output slot.
//   clk, rst   - clock, synchronous active-high reset
//   load, din  - write din into the slot (wins over drain)
//   drain      - downstream consumed the current token
//   valid, data- registered slot contents
module switch_out_slot #(
    parameter int unsigned DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              drain,
    input  logic [DWIDTH-1:0] din,
    output logic              valid,
    output logic [DWIDTH-1:0] data
);

    // Slot register: load refills even in the cycle it drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= din;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/switch_nxm_reg.sv
// switch_nxm_reg: N_IN x N_OUT switch with one registered slot per output.
// Inputs are visited round-robin from rr_ptr; each valid input takes the
// available slot with the lowest downstream latency.
//   clk, rst                  - clock, synchronous active-high reset
//   in_valid/in_data/in_ready - upstream token handshake (ready is combinational)
//   in_latency                - best downstream latency + 1, same on every lane
//   out_valid/out_data        - registered output slots
//   out_ready, out_latency    - downstream accept and per-output latency
module switch_nxm_reg
    import switch_pkg::*;
#(
    parameter int unsigned N_IN                = 2,
    parameter int unsigned N_OUT               = 2,
    parameter int unsigned DWIDTH              = 16,
    parameter int unsigned LATENCY_COUNT_WIDTH = LAT_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_IN-1:0]                  in_valid,
    input  logic [N_IN*DWIDTH-1:0]           in_data,
    output logic [N_IN-1:0]                  in_ready,
    output logic [N_IN*LATENCY_COUNT_WIDTH-1:0] in_latency,
    output logic [N_OUT-1:0]                 out_valid,
    output logic [N_OUT*DWIDTH-1:0]          out_data,
    input  logic [N_OUT-1:0]                 out_ready,
    input  logic [N_OUT*LATENCY_COUNT_WIDTH-1:0] out_latency
);

    localparam int unsigned LCW   = LATENCY_COUNT_WIDTH;
    localparam int unsigned PTR_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic [PTR_W-1:0]              rr_ptr;
    logic [PTR_W-1:0]              rr_ptr_nxt;
    logic [N_IN-1:0]               grant;
    logic [N_OUT-1:0]              load;
    logic [N_OUT-1:0]              drain;
    logic [N_OUT-1:0][DWIDTH-1:0]  slot_din;
    latency_t [MAX_OUT-1:0]        lats;
    latency_t                      lat_min;

    // Unpack downstream latencies; unused entries stay masked off in grant.
    always_comb begin
        lats = '0;
        for (int unsigned j = 0; j < N_OUT; j++) begin
            lats[j] = latency_t'(out_latency[j*LCW +: LCW]);
        end
    end

    // Advertised latency: independent of slot state and reset.
    always_comb begin
        lat_min = LAT_MAX;
        for (int unsigned j = 0; j < N_OUT; j++) begin
            if (lats[j] < lat_min) begin
                lat_min = lats[j];
            end
        end
        for (int unsigned i = 0; i < N_IN; i++) begin
            in_latency[i*LCW +: LCW] = LCW'(sat_inc(lat_min));
        end
    end

    // Round-robin grant: each valid input claims the best still-free slot.
    always_comb begin
        logic [MAX_OUT-1:0] avail;
        logic               found;
        int unsigned        idx;
        int unsigned        sel;

        grant      = '0;
        load       = '0;
        slot_din   = '0;
        rr_ptr_nxt = rr_ptr;
        found      = 1'b0;
        avail      = '0;
        idx        = 0;
        sel        = 0;

        for (int unsigned j = 0; j < N_OUT; j++) begin
            avail[j] = !out_valid[j] || out_ready[j];
        end

        if (!rst) begin
            for (int unsigned k = 0; k < N_IN; k++) begin
                idx = 32'(rr_ptr) + k;
                if (idx >= N_IN) begin
                    idx = idx - N_IN;
                end
                if (in_valid[idx] && (avail != '0)) begin
                    sel             = argmin_latency(avail, lats);
                    grant[idx]      = 1'b1;
                    load[sel]       = 1'b1;
                    slot_din[sel]   = in_data[idx*DWIDTH +: DWIDTH];
                    avail[sel]      = 1'b0;
                    if (!found) begin
                        found      = 1'b1;
                        rr_ptr_nxt = PTR_W'((idx + 1) % N_IN);
                    end
                end
            end
        end
    end

    assign in_ready = grant;
    assign drain    = out_valid & out_ready;

    // Fairness pointer: restarts after the first granted input.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_ptr_nxt;
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_slot
        switch_out_slot #(
            .DWIDTH (DWIDTH)
        ) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (load[j]),
            .drain (drain[j]),
            .din   (slot_din[j]),
            .valid (out_valid[j]),
            .data  (out_data[j*DWIDTH +: DWIDTH])
        );
    end

endmodule
